// File: rtl/dmem_resp.sv
// dmem_resp: single-port data memory responder for the core's data port.
// Accepts one word-aligned request at a time over valid/ready channels.
// Partial-word stores are serviced by read-modify-write, because the array
// has no byte enables.
module dmem_resp #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [XLEN-1:0]   req_addr,
    input  logic              req_we,
    input  logic [XLEN/8-1:0] req_wstrb,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err
);

    localparam int NB  = XLEN / 8;
    localparam int AW  = $clog2(DEPTH);
    localparam int OFF = $clog2(NB);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RSP
    } state_t;

    state_t state;
    state_t state_nxt;

    // Request fields held for the life of the transaction (data path, no reset)
    logic [AW-1:0]   idx;
    logic            we_q;
    logic [NB-1:0]   wstrb_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;

    logic [XLEN-1:0] mem [DEPTH];

    logic            accept;
    logic            range_err;
    logic [AW-1:0]   req_idx;
    logic            strb_full;
    logic            strb_none;
    logic [XLEN-1:0] rd_word;
    logic [XLEN-1:0] merged;
    logic            unused_addr_bits;

    // Byte-lane merge: strobed lanes come from the store data, the rest from
    // the word previously read out of the array.
    function automatic logic [XLEN-1:0] merge_word(
        input logic [XLEN-1:0] wd,
        input logic [XLEN-1:0] old,
        input logic [NB-1:0]   strb
    );
        logic [XLEN-1:0] res;
        res = old;
        for (int i = 0; i < NB; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = wd[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign req_ready        = (state == IDLE);
    assign rsp_valid        = (state == RSP);
    assign accept           = req_valid && req_ready;
    // Any address bit above the array's byte span makes the request invalid
    assign range_err        = (req_addr >> (AW + OFF)) != '0;
    assign req_idx          = req_addr[AW+OFF-1:OFF];
    assign strb_full        = &req_wstrb;
    assign strb_none        = ~|req_wstrb;
    assign rd_word          = mem[idx];
    // Full-strobe stores merge to wdata regardless of the stale read register
    assign merged           = merge_word(wdata_q, rdata_q, wstrb_q);
    assign unused_addr_bits = ^req_addr[OFF-1:0];

    // State register; reset drops any in-flight transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (range_err) begin
                        state_nxt = RSP;
                    end else if (!req_we) begin
                        state_nxt = RD;
                    end else if (strb_full) begin
                        state_nxt = WR;
                    end else if (strb_none) begin
                        state_nxt = RSP;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            RD:      state_nxt = we_q ? WR : RSP;
            WR:      state_nxt = RSP;
            RSP:     state_nxt = rsp_ready ? IDLE : RSP;
            default: state_nxt = IDLE;
        endcase
    end

    // Response payload registers, held stable until the response handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rsp_rdata <= '0;
                        rsp_err   <= range_err;
                    end
                end
                RD: begin
                    if (!we_q) begin
                        rsp_rdata <= rd_word;
                    end
                end
                WR: rsp_rdata <= '0;
                RSP: begin
                    if (rsp_ready) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Latch request fields on acceptance and the array word while in RD
    always_ff @(posedge clk) begin
        if (accept) begin
            idx     <= req_idx;
            we_q    <= req_we;
            wstrb_q <= req_wstrb;
            wdata_q <= req_wdata;
        end
        if (state == RD) begin
            rdata_q <= rd_word;
        end
    end

    // Array write port; an asynchronous reset leaves WR before this edge
    always_ff @(posedge clk) begin
        if (state == WR) begin
            mem[idx] <= merged;
        end
    end

endmodule
